// File: rtl/hash_row_serializer.sv
// hash_row_serializer
// Buffers one merged hash-row bundle and replays it as single-lane row beats,
// lowest lane first, carrying the bundle delimiter on the final beat.
`timescale 1ns/1ps

module hash_row_serializer #(
  parameter int unsigned HASH_ISSUE_WIDTH      = 8,
  parameter int unsigned HASH_ISSUE_WIDTH_LOG2 = 3,
  parameter int unsigned ROW_SIZE              = 4,
  parameter int unsigned ADDR_WIDTH            = 24
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          input_valid,
  input  logic [ADDR_WIDTH-1:0]                         input_head_addr,
  input  logic [HASH_ISSUE_WIDTH-1:0]                   input_row_valid,
  input  logic [HASH_ISSUE_WIDTH*ROW_SIZE-1:0]          input_history_valid_vec,
  input  logic [HASH_ISSUE_WIDTH*ROW_SIZE*ADDR_WIDTH-1:0] input_history_addr_vec,
  input  logic                                          input_delim,
  output logic                                          input_ready,
  output logic                                          output_valid,
  output logic [ADDR_WIDTH-1:0]                         output_head_addr,
  output logic [HASH_ISSUE_WIDTH_LOG2-1:0]              output_lane_idx,
  output logic [ROW_SIZE-1:0]                           output_history_valid_vec,
  output logic [ROW_SIZE*ADDR_WIDTH-1:0]                output_history_addr_vec,
  output logic                                          output_last,
  output logic                                          output_delim,
  input  logic                                          output_ready
);

  localparam int unsigned LANE_ADDR_W = ROW_SIZE * ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b01,
    S_DRAIN = 2'b10
  } state_t;

  state_t                                   r_state;
  logic [ADDR_WIDTH-1:0]                    r_head_addr;
  logic                                     r_delim;
  logic                                     r_empty;
  logic [HASH_ISSUE_WIDTH-1:0]              r_pending;
  logic [HASH_ISSUE_WIDTH*ROW_SIZE-1:0]     r_hist_valid;
  logic [HASH_ISSUE_WIDTH*LANE_ADDR_W-1:0]  r_hist_addr;

  logic [HASH_ISSUE_WIDTH_LOG2-1:0]         w_lane;
  logic                                     w_found;
  logic [HASH_ISSUE_WIDTH-1:0]              w_rest;
  logic                                     w_drain;
  logic                                     w_idle;
  logic                                     w_out_fire;
  logic                                     w_in_fire;

  // Priority encoder: lowest pending lane is the next beat.
  always_comb begin
    w_lane  = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < HASH_ISSUE_WIDTH; i++) begin
      if (!w_found && r_pending[i]) begin
        w_lane  = HASH_ISSUE_WIDTH_LOG2'(i);
        w_found = 1'b1;
      end
    end
  end

  // Handshake and beat decode.
  always_comb begin
    w_rest       = r_pending & (r_pending - HASH_ISSUE_WIDTH'(1));
    w_drain      = (r_state == S_DRAIN);
    w_idle       = (r_state == S_IDLE);
    output_valid = w_drain;
    output_last  = w_drain & (r_empty | (w_rest == '0));
    output_delim = output_last & r_delim;
    w_out_fire   = w_drain & output_ready;
    input_ready  = ~rst & (w_idle | (w_out_fire & output_last));
    w_in_fire    = input_valid & input_ready;
  end

  // Payload of the current beat; zero whenever no beat is presented.
  always_comb begin
    output_lane_idx          = '0;
    output_head_addr         = '0;
    output_history_valid_vec = '0;
    output_history_addr_vec  = '0;
    if (w_drain) begin
      output_lane_idx  = w_lane;
      output_head_addr = r_head_addr + ADDR_WIDTH'(w_lane);
      if (!r_empty) begin
        output_history_valid_vec = r_hist_valid[w_lane*ROW_SIZE +: ROW_SIZE];
        output_history_addr_vec  = r_hist_addr[w_lane*LANE_ADDR_W +: LANE_ADDR_W];
      end
    end
  end

  // Bundle buffer and drain state; a new bundle loads on the last beat's handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_head_addr  <= '0;
      r_delim      <= 1'b0;
      r_empty      <= 1'b0;
      r_pending    <= '0;
      r_hist_valid <= '0;
      r_hist_addr  <= '0;
    end else if (w_in_fire) begin
      r_head_addr  <= input_head_addr;
      r_delim      <= input_delim;
      r_pending    <= input_row_valid;
      r_hist_valid <= input_history_valid_vec;
      r_hist_addr  <= input_history_addr_vec;
      if (input_row_valid != '0) begin
        r_state <= S_DRAIN;
        r_empty <= 1'b0;
      end else if (input_delim) begin
        // empty bundle still owes one delimiter beat
        r_state <= S_DRAIN;
        r_empty <= 1'b1;
      end else begin
        r_state <= S_IDLE;
        r_empty <= 1'b0;
      end
    end else if (w_out_fire) begin
      if (output_last) begin
        r_state   <= S_IDLE;
        r_pending <= '0;
        r_empty   <= 1'b0;
      end else begin
        r_pending <= w_rest;
      end
    end
  end

endmodule
